// File: rtl/bcd_to_binary.sv
// Serial BCD-to-binary converter using reverse double-dabble.
// One output bit is produced per clock-enabled busy cycle. The block uses a
// start/done handshake; done_o is high whenever the converter is idle.
module bcd_to_binary #(
  parameter int BCD_DIGITS_IN_PP   = 5,
  parameter int BITS_OUT_PP        = 16,
  parameter int BIT_COUNT_WIDTH_PP = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          ce_i,
  input  logic                          start_i,
  input  logic [4*BCD_DIGITS_IN_PP-1:0] dat_bcd_i,
  output logic [BITS_OUT_PP-1:0]        dat_binary_o,
  output logic                          err_o,
  output logic                          ovf_o,
  output logic                          done_o
);

  localparam int BCD_W = 4 * BCD_DIGITS_IN_PP;
  localparam logic [BIT_COUNT_WIDTH_PP-1:0] LAST_STEP =
    BIT_COUNT_WIDTH_PP'(BITS_OUT_PP - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t                        state, state_next;
  logic [BCD_W-1:0]              bcd_reg, bcd_reg_next;
  logic [BITS_OUT_PP-1:0]        bin_reg, bin_reg_next;
  logic [BIT_COUNT_WIDTH_PP-1:0] bit_count, bit_count_next;
  logic [BITS_OUT_PP-1:0]        result_next;
  logic                          err_next, ovf_next;

  logic [BCD_W-1:0]              bcd_shifted;
  logic [BCD_W-1:0]              bcd_step;
  logic [BITS_OUT_PP-1:0]        bin_step;
  logic                          operand_invalid;

  // One reverse double-dabble step: shift right, then pull every digit >= 8 down by 3.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    bcd_shifted = bcd_reg >> 1;
    bcd_step    = '0;
    for (int k = 0; k < BCD_DIGITS_IN_PP; k++) begin
      bcd_step[4*k +: 4] = (bcd_shifted[4*k +: 4] >= 4'd8) ?
                           (bcd_shifted[4*k +: 4] - 4'd3) : bcd_shifted[4*k +: 4];
    end
    bin_step = {bcd_reg[0], bin_reg[BITS_OUT_PP-1:1]};
  end

  // Flag any input nibble that is not a decimal digit.
  always_comb begin
    operand_invalid = 1'b0;
    for (int k = 0; k < BCD_DIGITS_IN_PP; k++) begin
      if (dat_bcd_i[4*k +: 4] > 4'd9) operand_invalid = 1'b1;
    end
  end

  // Next-state and datapath update: accept while idle, shift on enabled busy cycles.
  always_comb begin
    state_next     = state;
    bcd_reg_next   = bcd_reg;
    bin_reg_next   = bin_reg;
    bit_count_next = bit_count;
    result_next    = dat_binary_o;
    err_next       = err_o;
    ovf_next       = ovf_o;
    case (state)
      ST_IDLE: begin
        if (start_i) begin
          state_next     = ST_BUSY;
          bcd_reg_next   = dat_bcd_i;
          bin_reg_next   = '0;
          bit_count_next = '0;
          err_next       = operand_invalid;
          ovf_next       = 1'b0;
        end
      end
      ST_BUSY: begin
        if (ce_i) begin
          if (bit_count == LAST_STEP) begin
            state_next     = ST_IDLE;
            result_next    = bin_step;
            ovf_next       = (bcd_step != '0);
            bit_count_next = '0;
            bcd_reg_next   = bcd_step;
            bin_reg_next   = bin_step;
          end else begin
            bcd_reg_next   = bcd_step;
            bin_reg_next   = bin_step;
            bit_count_next = bit_count + 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst_i) begin
      state        <= ST_IDLE;
      bcd_reg      <= '0;
      bin_reg      <= '0;
      bit_count    <= '0;
      dat_binary_o <= '0;
      err_o        <= 1'b0;
      ovf_o        <= 1'b0;
    end else begin
      state        <= state_next;
      bcd_reg      <= bcd_reg_next;
      bin_reg      <= bin_reg_next;
      bit_count    <= bit_count_next;
      dat_binary_o <= result_next;
      err_o        <= err_next;
      ovf_o        <= ovf_next;
    end
  end

  assign done_o = (state == ST_IDLE);

endmodule
